// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        SHOW = 3'd2,
        HIT  = 3'd3,
        MISS = 3'd4,
        OVER = 3'd5
    } state_t;

    // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int         DEF_N_HOLES        = 4;
    localparam int         DEF_SCORE_W        = 8;
    localparam int         DEF_MAX_MISS       = 3;
    localparam int         DEF_INIT_INTERVAL  = 7;
    localparam int         DEF_MIN_INTERVAL   = 2;
    localparam int         DEF_HITS_PER_LEVEL = 4;
    localparam logic [7:0] DEF_LFSR_SEED      = 8'hA5;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Player/timer side signals of the round controller.
interface mole_round_ctrl_if #(
    parameter int N_HOLES = 4,
    parameter int SCORE_W = 8
);
    logic               start;
    logic [N_HOLES-1:0] btn;
    logic               timeout;
    logic [2:0]         interval;
    logic               dir;
    logic               timer_clr;
    logic [N_HOLES-1:0] mole;
    logic [SCORE_W-1:0] score;
    logic [2:0]         misses;
    logic               game_over;

    modport slave (
        input  start, btn, timeout,
        output interval, dir, timer_clr, mole, score, misses, game_over
    );

    modport master (
        output start, btn, timeout,
        input  interval, dir, timer_clr, mole, score, misses, game_over
    );
endinterface

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the next mole.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= SEED;
        else        value <= {value[6:0], ^(value & LFSR_TAPS)};
    end

endmodule

// File: rtl/mole_round_ctrl.sv
// Game-round controller: picks moles, detects hits/misses, keeps score and
// drives the downstream timer's interval and restart pulse.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int         N_HOLES        = DEF_N_HOLES,
    parameter int         SCORE_W        = DEF_SCORE_W,
    parameter int         MAX_MISS       = DEF_MAX_MISS,
    parameter int         INIT_INTERVAL  = DEF_INIT_INTERVAL,
    parameter int         MIN_INTERVAL   = DEF_MIN_INTERVAL,
    parameter int         HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
    parameter logic [7:0] LFSR_SEED      = DEF_LFSR_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    mole_round_ctrl_if.slave bus
);

    localparam int HL_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

    state_t             state;
    logic [7:0]         lfsr;
    logic [N_HOLES-1:0] btn_q;
    logic               timeout_q;
    logic [2:0]         prev_idx;
    logic [HL_W-1:0]    hit_lvl_cnt;

    logic [N_HOLES-1:0] mole;
    logic [SCORE_W-1:0] score;
    logic [2:0]         misses;
    logic [2:0]         interval;
    logic               timer_clr;
    logic               game_over;

    logic [N_HOLES-1:0] btn_rise;
    logic               to_rise;
    logic               hit;
    logic [2:0]         cand;
    logic [2:0]         idx;
    logic [7:0]         oh;
    logic [N_HOLES-1:0] mole_next;
    logic [2:0]         misses_next;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr)
    );

    always_comb begin
        btn_rise    = bus.btn & ~btn_q;
        to_rise     = bus.timeout & ~timeout_q;
        hit         = |(btn_rise & mole);
        cand        = 3'(lfsr % 8'(N_HOLES));
        // never show the same hole twice in a row
        idx         = (cand == prev_idx) ? 3'(({1'b0, cand} + 4'd1) % 4'(N_HOLES)) : cand;
        oh          = onehot(idx);
        mole_next   = oh[N_HOLES-1:0];
        misses_next = misses + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mole        <= '0;
            score       <= '0;
            misses      <= '0;
            game_over   <= 1'b0;
            timer_clr   <= 1'b0;
            interval    <= 3'(INIT_INTERVAL);
            hit_lvl_cnt <= '0;
            prev_idx    <= '0;
            btn_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            btn_q     <= bus.btn;
            timeout_q <= bus.timeout;
            timer_clr <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    mole <= '0;
                    if (bus.start) begin
                        score       <= '0;
                        misses      <= '0;
                        hit_lvl_cnt <= '0;
                        interval    <= 3'(INIT_INTERVAL);
                        game_over   <= 1'b0;
                        timer_clr   <= 1'b1;
                        state       <= ARM;
                    end
                end
                ARM: begin
                    mole     <= mole_next;
                    prev_idx <= idx;
                    state    <= SHOW;
                end
                SHOW: begin
                    if (hit)          state <= HIT;
                    else if (to_rise) state <= MISS;
                end
                HIT: begin
                    mole      <= '0;
                    score     <= (&score) ? score : score + 1'b1;
                    timer_clr <= 1'b1;
                    state     <= ARM;
                    if (hit_lvl_cnt == HL_W'(HITS_PER_LEVEL - 1)) begin
                        hit_lvl_cnt <= '0;
                        if (interval > 3'(MIN_INTERVAL)) interval <= interval - 3'd1;
                    end else begin
                        hit_lvl_cnt <= hit_lvl_cnt + 1'b1;
                    end
                end
                MISS: begin
                    mole   <= '0;
                    misses <= misses_next;
                    if (misses_next == 3'(MAX_MISS)) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        timer_clr <= 1'b1;
                        state     <= ARM;
                    end
                end
                default: begin
                    mole  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mole      = mole;
    assign bus.score     = score;
    assign bus.misses    = misses;
    assign bus.interval  = interval;
    assign bus.timer_clr = timer_clr;
    assign bus.game_over = game_over;
    assign bus.dir       = 1'b0;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed-random bench for mole_round_ctrl against a score/LFSR reference model.
module tb_mole_round_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mole_round_ctrl_if #(.N_HOLES(4), .SCORE_W(8)) bus ();

    mole_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // reference state
    logic [7:0] m_lfsr;
    int m_prev, m_score, m_misses;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic int exp_interval();
        int v;
        v = 7 - m_score / 4;
        return (v < 2) ? 2 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // called at the negedge while the DUT sits in ARM
    task automatic arm_check();
        int cand, idx;
        chk("arm_timer_clr", 32'(bus.timer_clr), 1);
        chk("arm_mole_off", 32'(bus.mole), 0);
        chk("arm_dir", 32'(bus.dir), 0);
        cand = int'(m_lfsr) % 4;
        idx  = (cand == m_prev) ? (cand + 1) % 4 : cand;
        m_prev = idx;
        @(negedge clk);
        chk("show_mole", 32'(bus.mole), 32'(1 << idx));
        chk("show_clr_low", 32'(bus.timer_clr), 0);
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        m_score = 0;
        m_misses = 0;
        chk("start_game_over", 32'(bus.game_over), 0);
        chk("start_interval", 32'(bus.interval), 7);
        chk("start_score", 32'(bus.score), 0);
        chk("start_misses", 32'(bus.misses), 0);
        arm_check();
    endtask

    task automatic hit_round(input bit both, input bit hold_to);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.btn = 4'(1 << m_prev);
        if (both) bus.timeout = 1'b1;
        @(negedge clk);
        chk("hit_score_pending", 32'(bus.score), 32'(m_score));
        bus.btn = '0;
        bus.timeout = 1'b0;
        @(negedge clk);
        m_score++;
        chk("hit_score", 32'(bus.score), 32'(m_score));
        chk("hit_misses", 32'(bus.misses), 32'(m_misses));
        chk("hit_interval", 32'(bus.interval), 32'(exp_interval()));
        if (hold_to) bus.timeout = 1'b1;
        arm_check();
    endtask

    task automatic miss_round();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.timeout = 1'b1;
        @(negedge clk);
        chk("miss_pending", 32'(bus.misses), 32'(m_misses));
        bus.timeout = 1'b0;
        @(negedge clk);
        m_misses++;
        chk("miss_count", 32'(bus.misses), 32'(m_misses));
        chk("miss_score", 32'(bus.score), 32'(m_score));
        if (m_misses == 3) begin
            chk("over_flag", 32'(bus.game_over), 1);
            chk("over_mole", 32'(bus.mole), 0);
            chk("over_clr", 32'(bus.timer_clr), 0);
        end else begin
            chk("miss_not_over", 32'(bus.game_over), 0);
            arm_check();
        end
    endtask

    initial begin
        int w;
        bus.start = 1'b0;
        bus.btn = '0;
        bus.timeout = 1'b0;
        m_prev = 0;
        m_score = 0;
        m_misses = 0;
        repeat (2) @(negedge clk);
        chk("rst_mole", 32'(bus.mole), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_misses", 32'(bus.misses), 0);
        chk("rst_game_over", 32'(bus.game_over), 0);
        chk("rst_timer_clr", 32'(bus.timer_clr), 0);
        chk("rst_interval", 32'(bus.interval), 7);
        chk("rst_dir", 32'(bus.dir), 0);
        rst_n = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);

        // game 1: one hit, then three misses end the game
        start_game();
        hit_round(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) miss_round();
        bus.btn = 4'hF;
        repeat (2) @(negedge clk);
        bus.btn = '0;
        chk("over_score_held", 32'(bus.score), 32'(m_score));
        chk("over_flag_held", 32'(bus.game_over), 1);
        chk("over_misses_held", 32'(bus.misses), 3);

        // game 2: restart from OVER, simultaneous hit/timeout, long hit streak
        start_game();
        hit_round(1'b1, 1'b0);
        chk("both_misses", 32'(bus.misses), 0);
        for (int i = 0; i < 24; i++) hit_round(1'b0, 1'b0);
        chk("interval_floor", 32'(bus.interval), 2);

        // timeout already high on entering SHOW must not count
        hit_round(1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("to_high_misses", 32'(bus.misses), 32'(m_misses));
            chk("to_high_mole", 32'(bus.mole), 32'(1 << m_prev));
        end
        bus.timeout = 1'b0;
        @(negedge clk);
        miss_round();

        // wrong button and start are both ignored in SHOW
        w = (m_prev + 1 + int'($urandom_range(0, 2))) % 4;
        bus.btn = 4'(1 << w);
        repeat (3) begin
            @(negedge clk);
            chk("wrong_mole", 32'(bus.mole), 32'(1 << m_prev));
            chk("wrong_score", 32'(bus.score), 32'(m_score));
            chk("wrong_clr", 32'(bus.timer_clr), 0);
        end
        bus.btn = '0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_ignored_clr", 32'(bus.timer_clr), 0);
        chk("start_ignored_mole", 32'(bus.mole), 32'(1 << m_prev));

        // asynchronous reset mid-SHOW, sampled between clock edges
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_mole", 32'(bus.mole), 0);
        chk("async_rst_score", 32'(bus.score), 0);
        chk("async_rst_misses", 32'(bus.misses), 0);
        chk("async_rst_interval", 32'(bus.interval), 7);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_prev = 0;
        m_score = 0;
        m_misses = 0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_mole", 32'(bus.mole), 0);
            chk("idle_clr", 32'(bus.timer_clr), 0);
        end
        start_game();
        hit_round(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
